// File: rtl/aes_pkg.sv
// +--------------------------------------------------------------------+
// | aes_pkg : tables, GF(2^8) helpers and FSM states for decryption    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    INIT   = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  // Indexed by round-key number / 2; entry 0 is never used.
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  function automatic logic [7:0] xor_fold(input logic [127:0] v);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 16; i++) acc = acc ^ v[127-8*i -: 8];
    return acc;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w, input logic [7:0] m,
                                           input logic [7:0] n);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[31-8*i -: 8] = SBOX[w[31-8*i -: 8] ^ m] ^ n;
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s, input logic [7:0] m,
                                                 input logic [7:0] n);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8] ^ n] ^ m;
    return r;
  endfunction

  // Row r of the column-major state rotates right by r byte positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c-row+4)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_expand_step.sv
// +--------------------------------------------------------------------+
// | aes_key_expand_step : next AES-256 round key from the previous two |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] prev2_key,
  input  logic [127:0] prev1_key,
  input  logic [3:0]   step,
  input  logic [7:0]   mask_m,
  input  logic [7:0]   mask_n,
  output logic [127:0] next_key
);

  logic [31:0] temp;
  logic [31:0] w0, w1, w2, w3;

  // Even round keys start at a word index divisible by 8 (RotWord + Rcon);
  // odd ones start at index 4 mod 8 (SubWord only).
  always_comb begin
    if (step[0] == 1'b0) begin
      temp = sub_word({prev1_key[23:0], prev1_key[31:24]}, mask_m, mask_n)
             ^ {RCON[step[3:1]], 24'h000000};
    end else begin
      temp = sub_word(prev1_key[31:0], mask_m, mask_n);
    end
    w0 = prev2_key[127:96] ^ temp;
    w1 = prev2_key[95:64]  ^ w0;
    w2 = prev2_key[63:32]  ^ w1;
    w3 = prev2_key[31:0]   ^ w2;
    next_key = {w0, w1, w2, w3};
  end

endmodule

`default_nettype wire

// File: rtl/decryption.sv
// +--------------------------------------------------------------------+
// | decryption : iterative AES-256 decryptor with seed-masked S-box    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module decryption
  import aes_pkg::*;
#(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [255:0] key,
  input  logic [255:0] sbox_seed,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rk_q [NR+1];
  logic [127:0] rk_d [NR+1];
  logic [127:0] st_q, st_d;
  logic [7:0]   m_q, m_d;
  logic [7:0]   n_q, n_d;
  logic [127:0] out_q, out_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] next_key;

  aes_key_expand_step u_key_step (
    .prev2_key (rk_q[cnt_q - 4'd2]),
    .prev1_key (rk_q[cnt_q - 4'd1]),
    .step      (cnt_q),
    .mask_m    (m_q),
    .mask_n    (n_q),
    .next_key  (next_key)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rk_d    = rk_q;
    st_d    = st_q;
    m_d     = m_q;
    n_d     = n_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // The ciphertext is held in the state register until INIT.
        if (start) begin
          st_d    = in;
          rk_d[0] = key[255:128];
          rk_d[1] = key[127:0];
          m_d     = xor_fold(sbox_seed[255:128]);
          n_d     = xor_fold(sbox_seed[127:0]);
          cnt_d   = 4'd2;
          busy_d  = 1'b1;
          state_d = KEYEXP;
        end
      end
      KEYEXP: begin
        rk_d[cnt_q] = next_key;
        if (cnt_q == 4'(NR)) begin
          state_d = INIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      INIT: begin
        st_d    = st_q ^ rk_q[NR];
        cnt_d   = 4'(NR - 1);
        state_d = ROUND;
      end
      ROUND: begin
        st_d = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q), m_q, n_q) ^ rk_q[cnt_q]);
        if (cnt_q == 4'd1) begin
          state_d = FINAL;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FINAL: begin
        out_d   = inv_sub_bytes(inv_shift_rows(st_q), m_q, n_q) ^ rk_q[0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      st_q    <= '0;
      m_q     <= 8'h00;
      n_q     <= 8'h00;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
      st_q    <= st_d;
      m_q     <= m_d;
      n_q     <= n_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_decryption.sv
// +--------------------------------------------------------------------+
// | tb_decryption : scoreboard bench for the decryption block          |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_decryption;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] in_blk;
  logic [255:0] key;
  logic [255:0] sbox_seed;
  logic [127:0] out;
  logic         busy;
  logic         done;

  decryption dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (in_blk),
    .key       (key),
    .sbox_seed (sbox_seed),
    .out       (out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [31:0]  w   [60];
  logic [7:0]   st  [16];
  bit           busy_err;

  localparam logic [127:0] KV_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KV_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KV_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] MSEED  = {{16{8'h01}}, 120'h0, 8'h5a};

  // ---------------- reference model (S-box derived from GF inverse + affine) ----
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [7:0] fold(input logic [127:0] v);
    logic [7:0] a;
    a = 8'h00;
    for (int i = 0; i < 16; i++) a = a ^ v[8*i +: 8];
    return a;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t, input logic [7:0] m, input logic [7:0] n);
    return {sb[t[31:24]^m]^n, sb[t[23:16]^m]^n, sb[t[15:8]^m]^n, sb[t[7:0]^m]^n};
  endfunction

  task automatic model_expand(input logic [255:0] k, input logic [7:0] m, input logic [7:0] n);
    logic [7:0]  rc;
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}, m, n) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t, m, n);
      end
      w[i] = w[i-8] ^ t;
    end
  endtask

  task automatic add_rk(input int r);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) st[4*c+k] = st[4*c+k] ^ w[4*r+c][31-8*k -: 8];
  endtask

  task automatic shift_rows(input bit inverse);
    logic [7:0] t [16];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = inverse ? st[r+4*((c-r+4)%4)] : st[r+4*((c+r)%4)];
    st = t;
  endtask

  task automatic mix_cols(input bit inverse);
    logic [7:0] a [4];
    logic [7:0] k0, k1, k2, k3;
    k0 = inverse ? 8'h0e : 8'h02;
    k1 = inverse ? 8'h0b : 8'h03;
    k2 = inverse ? 8'h0d : 8'h01;
    k3 = inverse ? 8'h09 : 8'h01;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = st[4*c+i];
      for (int i = 0; i < 4; i++)
        st[4*c+i] = gm(a[i], k0) ^ gm(a[(i+1)%4], k1) ^ gm(a[(i+2)%4], k2) ^ gm(a[(i+3)%4], k3);
    end
  endtask

  task automatic sub_bytes(input bit inverse, input logic [7:0] m, input logic [7:0] n);
    for (int i = 0; i < 16; i++) st[i] = inverse ? (isb[st[i]^n] ^ m) : (sb[st[i]^m] ^ n);
  endtask

  task automatic model_cipher(input bit dec, input logic [127:0] blk, input logic [255:0] k,
                              input logic [255:0] seed, output logic [127:0] res);
    logic [7:0] m;
    logic [7:0] n;
    m = fold(seed[255:128]);
    n = fold(seed[127:0]);
    model_expand(k, m, n);
    for (int i = 0; i < 16; i++) st[i] = blk[127-8*i -: 8];
    if (dec) begin
      add_rk(14);
      for (int r = 13; r >= 1; r--) begin
        shift_rows(1'b1); sub_bytes(1'b1, m, n); add_rk(r); mix_cols(1'b1);
      end
      shift_rows(1'b1); sub_bytes(1'b1, m, n); add_rk(0);
    end else begin
      add_rk(0);
      for (int r = 1; r <= 13; r++) begin
        sub_bytes(1'b0, m, n); shift_rows(1'b0); mix_cols(1'b0); add_rk(r);
      end
      sub_bytes(1'b0, m, n); shift_rows(1'b0); add_rk(14);
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
  endtask

  // ---------------- stimulus helpers (no checking) -------------------------------
  // Called at a negedge; returns at the negedge after the sampling edge (edge 1).
  task automatic drive_start(input logic [127:0] b, input logic [255:0] k, input logic [255:0] s);
    in_blk    = b;
    key       = k;
    sbox_seed = s;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int first, output int edges);
    edges    = first;
    busy_err = 1'b0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy !== 1'b1) busy_err = 1'b1;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_blk = '0; key = '0; sbox_seed = '0;
    idle_cycles(3);
    n_checks++;
    if (out !== 128'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%h busy=%b done=%b, required out=0 busy=0 done=0", out, busy, done);
    end
    rst = 1'b0;
    idle_cycles(2);
    n_checks++;
    if (out !== 128'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: out=%h busy=%b done=%b, required all zero", out, busy, done);
    end
  endtask

  task automatic test_zero_mask();
    int edges;
    logic [127:0] e;
    exp_q.push_back(KV_PT);
    drive_start(KV_CT, KV_KEY, KV_KEY);
    wait_done(1, edges);
    e = exp_q.pop_front();
    n_checks++;
    if (edges != 29) begin
      n_fail++; $display("FAIL zero_mask_latency: done at edge %0d, required 29", edges);
    end
    n_checks++;
    if (out !== e) begin
      n_fail++; $display("FAIL zero_mask_out: out=%h, required %h", out, e);
    end
    n_checks++;
    if (busy_err || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_mask_busy: busy_gap=%b busy_at_done=%b, required 0 and 0", busy_err, busy);
    end
    idle_cycles(1);
    n_checks++;
    if (done !== 1'b0 || out !== e) begin
      n_fail++; $display("FAIL done_one_cycle: done=%b out=%h, required done=0 out=%h", done, out, e);
    end
  endtask

  task automatic test_mask();
    int edges;
    logic [127:0] e;
    model_cipher(1'b1, KV_CT, KV_KEY, MSEED, e);
    exp_q.push_back(e);
    drive_start(KV_CT, KV_KEY, MSEED);
    wait_done(1, edges);
    e = exp_q.pop_front();
    n_checks++;
    if (edges != 29 || out !== e) begin
      n_fail++; $display("FAIL mask_out: out=%h edge=%0d, required %h at edge 29", out, edges, e);
    end
    n_checks++;
    if (out === KV_PT) begin
      n_fail++; $display("FAIL mask_differs: out=%h, required a value other than %h", out, KV_PT);
    end
  endtask

  // Each new start is raised in the cycle where done is high, so blocks run back to back.
  task automatic test_round_trip();
    int edges;
    int bad = 0;
    logic [127:0] pt, ct, e;
    logic [255:0] k, s;
    idle_cycles(2);
    for (int it = 0; it < 100; it++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      s  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model_cipher(1'b0, pt, k, s, ct);
      exp_q.push_back(pt);
      drive_start(ct, k, s);
      wait_done(1, edges);
      e = exp_q.pop_front();
      n_checks++;
      if (edges != 29 || out !== e) begin
        n_fail++;
        if (bad < 5) $display("FAIL round_trip[%0d]: out=%h edge=%0d, required %h at edge 29", it, out, edges, e);
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    bit seen = 1'b0;
    logic [127:0] e;
    idle_cycles(2);
    drive_start(KV_CT, KV_KEY, MSEED);
    idle_cycles(8);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out !== 128'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_state: out=%h busy=%b done=%b, required all zero", out, busy, done);
    end
    rst = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      idle_cycles(1);
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL reset_mid_abort: done_or_busy_seen=%b, required 0", seen);
    end
    exp_q.push_back(KV_PT);
    drive_start(KV_CT, KV_KEY, KV_KEY);
    wait_done(1, edges);
    e = exp_q.pop_front();
    n_checks++;
    if (edges != 29 || out !== e) begin
      n_fail++; $display("FAIL reset_mid_restart: out=%h edge=%0d, required %h at edge 29", out, edges, e);
    end
  endtask

  task automatic test_start_while_busy();
    int edges;
    bit extra = 1'b0;
    logic [127:0] e;
    idle_cycles(2);
    exp_q.push_back(KV_PT);
    drive_start(KV_CT, KV_KEY, KV_KEY);
    idle_cycles(3);
    drive_start(~KV_CT, KV_KEY, KV_KEY);
    wait_done(5, edges);
    e = exp_q.pop_front();
    n_checks++;
    if (edges != 29 || out !== e) begin
      n_fail++; $display("FAIL start_while_busy: out=%h edge=%0d, required %h at edge 29", out, edges, e);
    end
    idle_cycles(1);
    for (int i = 0; i < 35; i++) begin
      if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
      idle_cycles(1);
    end
    n_checks++;
    if (extra) begin
      n_fail++; $display("FAIL start_while_busy_ignored: second_op_seen=%b, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    logic [127:0] e;
    exp_q.push_back(KV_PT);
    drive_start(KV_CT, KV_KEY, KV_KEY);
    wait_done(1, edges);
    e = exp_q.pop_front();
    n_checks++;
    if (out !== e) begin
      n_fail++; $display("FAIL b2b_first: out=%h, required %h", out, e);
    end
    model_cipher(1'b1, KV_CT, KV_KEY, MSEED, e);
    exp_q.push_back(e);
    drive_start(KV_CT, KV_KEY, MSEED);
    wait_done(1, edges);
    e = exp_q.pop_front();
    n_checks++;
    if (edges != 29 || out !== e) begin
      n_fail++; $display("FAIL b2b_second: out=%h edge=%0d, required %h at edge 29", out, edges, e);
    end
  endtask

  task automatic test_input_stability();
    int edges;
    logic [127:0] pt, ct, e;
    logic [255:0] k, s;
    idle_cycles(2);
    pt = {$urandom, $urandom, $urandom, $urandom};
    k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    model_cipher(1'b0, pt, k, s, ct);
    exp_q.push_back(pt);
    drive_start(ct, k, s);
    idle_cycles(1);
    in_blk = ~ct; key = ~k; sbox_seed = {s[127:0], s[255:128] ^ 256'h0};
    sbox_seed[7:0] = sbox_seed[7:0] ^ 8'h3c;
    wait_done(2, edges);
    e = exp_q.pop_front();
    n_checks++;
    if (edges != 29 || out !== e) begin
      n_fail++; $display("FAIL input_stability: out=%h edge=%0d, required %h at edge 29", out, edges, e);
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_zero_mask();
    test_mask();
    test_round_trip();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    test_input_stability();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/decryption.md
Name: decryption

Overview:
- Iterative, clocked decryptor for a modified AES-256. The modification is a seed-dependent, byte-masked S-box.
- Takes a 128-bit ciphertext block, a 256-bit key and a 256-bit S-box seed, and returns the 128-bit plaintext after a fixed latency.
- Sits on the receive path of the Modified_AES256 datapath and is the inverse of the team's encryptor that uses the same key and seed.

Parameters:
- NR, 14, number of AES rounds. Fixed for AES-256; not intended to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request; `in`, `key` and `sbox_seed` are sampled on this edge.
- in  in  128  ciphertext block; byte 0 = bits [127:120], column-major state as in FIPS-197.
- key  in  256  cipher key; word w0 = bits [255:224].
- sbox_seed  in  256  S-box seed.
- out  out  128  plaintext, registered.
- busy  out  1  high from the edge that samples `start` until the edge that asserts `done`.
- done  out  1  one-cycle pulse; `out` is valid from this cycle onward.

Behaviour:
- Reset: `out` = 0, `busy` = 0, `done` = 0, FSM = IDLE, all key/state registers cleared. Reset asserted mid-operation aborts immediately and produces no `done`.
- Modified S-box:
  - m = XOR of the 16 bytes of sbox_seed[255:128]; n = XOR of the 16 bytes of sbox_seed[127:0].
  - S'(x) = S(x ^ m) ^ n, and InvS'(y) = InvS(y ^ n) ^ m, where S / InvS are the FIPS-197 tables.
  - m and n are computed once, from the seed latched at `start`.
- Key expansion: standard AES-256 schedule (Nk=8, Rcon 01..40), with SubWord using S'. Round keys rk0..rk14 are 128 bits each.
- FSM states and timing. Edges are counted from the edge that samples `start` (edge 1).
  - IDLE: on `start`, latch inputs, load rk0 = key[255:128] and rk1 = key[127:0], set busy = 1, go to KEYEXP (edge 1).
  - KEYEXP: produce one round key per edge, rk2..rk14 (edges 2-14).
  - INIT: state = in ^ rk14 (edge 15).
  - ROUND, for r = 13 down to 1 (edges 16-28): state = InvMixColumns(AddRoundKey(InvSubBytes'(InvShiftRows(state)), rk_r)).
  - FINAL: out = InvSubBytes'(InvShiftRows(state)) ^ rk0; done = 1; busy = 0; return to IDLE (edge 29).
  - Fixed latency: `done` is high in the cycle after edge 29.
- `start` while busy is ignored. `start` in the same cycle as `done` is accepted, and the next operation begins.
- `out` holds its value until the next FINAL or reset. `done` is high for exactly one cycle.
- Changing the inputs after `start` has no effect on the result in flight.
- GF(2^8) arithmetic uses the polynomial 0x11B. InvMixColumns uses the coefficients {0e, 0b, 0d, 09}.

Decomposition:
- Package aes_pkg holds:
  - the SBOX and INV_SBOX constant tables;
  - the RCON array;
  - the functions xtime, gmul, inv_shift_rows, inv_mix_columns and sub_word;
  - the state enum {IDLE, KEYEXP, INIT, ROUND, FINAL}.
- One sub-module, aes_key_expand_step, is natural: a combinational unit that takes the previous two round keys, the step index and m/n, and returns the next round key.
- Round-key storage (15 x 128 bits) and the FSM stay in decryption.

Test Plan:
- Zero-mask check: in = 8ea2b7ca516745bfeafc49904b496089, key = 000102…1f, seed = 000102…1f (m = n = 0). Expect out = 00112233445566778899aabbccddeeff, done exactly at edge 29, and busy high on edges 1-28.
- Mask sensitivity: same in and key, seed = all-0x01 in the upper half (m = 0x00, since 16 equal bytes cancel) and byte 15 = 0x5a in the lower half (n = 0x5a). Expect out to differ from the zero-mask result. Check equality against the reference model's output.
- Round trip: random key, seed and plaintext; encrypt with the model's S'; feed the ciphertext to the DUT. Expect out == plaintext. Run 100 iterations.
- Reset mid-operation: assert rst at edge 10. Expect out = 0, done never pulses, busy = 0. A new `start` afterwards gives the correct result 29 edges later.
- Start while busy: pulse `start` again at edge 5 with a different `in`. Expect the result of the first block only, at edge 29. Back-to-back `start` coincident with `done` gives the second result 29 edges later.
- Input stability: change `in`, `key` and `sbox_seed` on edge 3. Expect out to equal the result computed from the values latched at edge 1.
